// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic ops plus iterative unsigned mul/div with a start/busy/done handshake.
// Optional `ALU_OVF_EN adds a registered signed-overflow flag (ALU_Overflow) for add/sub.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUOp,
    input  logic [WIDTH-1:0] ALU_DA,
    input  logic [WIDTH-1:0] ALU_DB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALU_DC,
    output logic [WIDTH-1:0] ALU_HI,
    output logic             ALU_Zero
`ifdef ALU_OVF_EN
    ,
    output logic             ALU_Overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   dc_q, dc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef ALU_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [WIDTH-1:0]   add_s, sub_s;
    logic [WIDTH-1:0]   sc_dc_s;
    logic               sc_ovf_s;
    logic               is_multi_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic [2*WIDTH-1:0] div_next_s;

    assign add_s      = ALU_DA + ALU_DB;
    assign sub_s      = ALU_DA - ALU_DB;
    assign is_multi_s = (ALUOp == OP_MUL) || (ALUOp == OP_DIV);

    // Single-cycle result and signed overflow for the op presented with start
    always_comb begin
        sc_dc_s  = '0;
        sc_ovf_s = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                sc_dc_s  = add_s;
                sc_ovf_s = (ALU_DA[WIDTH-1] == ALU_DB[WIDTH-1]) && (add_s[WIDTH-1] != ALU_DA[WIDTH-1]);
            end
            OP_SUB: begin
                sc_dc_s  = sub_s;
                sc_ovf_s = (ALU_DA[WIDTH-1] != ALU_DB[WIDTH-1]) && (sub_s[WIDTH-1] != ALU_DA[WIDTH-1]);
            end
            OP_AND:  sc_dc_s = ALU_DA & ALU_DB;
            OP_OR:   sc_dc_s = ALU_DA | ALU_DB;
            OP_XOR:  sc_dc_s = ALU_DA ^ ALU_DB;
            default: sc_dc_s = '0;
        endcase
    end

    // One shift-add step: acc = {partial product high, remaining multiplier bits}
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    end

    // One restoring-divide step: acc = {partial remainder, dividend/quotient shift register}
    always_comb begin
        rem_sh_s   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_s = {1'b0, rem_sh_s} - {2'b00, b_q};
        if (div_diff_s[WIDTH+1]) begin
            div_next_s = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Control FSM and result capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        dc_d     = dc_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef ALU_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (is_multi_s) begin
                        is_div_d = (ALUOp == OP_DIV);
                        a_d      = ALU_DA;
                        b_d      = ALU_DB;
                        acc_d    = {{WIDTH{1'b0}}, ALU_DA};
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = ST_CALC;
                    end else begin
                        dc_d    = sc_dc_s;
                        hi_d    = '0;
                        zero_d  = (sc_dc_s == '0);
`ifdef ALU_OVF_EN
                        ovf_d   = sc_ovf_s;
`endif
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d = is_div_q ? div_next_s : mul_next_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Divide by zero bypasses the iterated value with a fixed result
                    if (is_div_q && (b_q == '0)) begin
                        dc_d = '1;
                        hi_d = a_q;
                    end else begin
                        dc_d = acc_d[WIDTH-1:0];
                        hi_d = acc_d[2*WIDTH-1:WIDTH];
                    end
                    zero_d  = (dc_d == '0);
`ifdef ALU_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dc_q     <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dc_q     <= dc_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef ALU_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ALU_DC   = dc_q;
    assign ALU_HI   = hi_q;
    assign ALU_Zero = zero_q;
`ifdef ALU_OVF_EN
    assign ALU_Overflow = ovf_q;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = sc_ovf_s;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32) with hand-computed expected values.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  ALUOp;
    logic [31:0] ALU_DA;
    logic [31:0] ALU_DB;
    logic        busy;
    logic        done;
    logic [31:0] ALU_DC;
    logic [31:0] ALU_HI;
    logic        ALU_Zero;
`ifdef ALU_OVF_EN
    logic        ALU_Overflow;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ALUOp    (ALUOp),
        .ALU_DA   (ALU_DA),
        .ALU_DB   (ALU_DB),
        .busy     (busy),
        .done     (done),
        .ALU_DC   (ALU_DC),
        .ALU_HI   (ALU_HI),
        .ALU_Zero (ALU_Zero)
`ifdef ALU_OVF_EN
        ,
        .ALU_Overflow (ALU_Overflow)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        ALUOp  = op;
        ALU_DA = a;
        ALU_DB = b;
        tick();
        start  = 1'b0;
    endtask

    // Checks busy for the 32 CALC cycles, then leaves time at the done cycle
    task automatic run_calc(input string tag);
        for (int i = 1; i <= 32; i++) begin
            chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
            chk({tag, "_nodone"}, {63'd0, done}, 64'd0);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ALUOp = 3'b000; ALU_DA = 32'd0; ALU_DB = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dc", {32'd0, ALU_DC}, 64'd0);
        chk("rst_hi", {32'd0, ALU_HI}, 64'd0);
        chk("rst_zero", {63'd0, ALU_Zero}, 64'd0);

        // add overflow boundary
        issue(3'b000, 32'h7FFF_FFFF, 32'd1);
        chk("add_done", {63'd0, done}, 64'd1);
        chk("add_busy", {63'd0, busy}, 64'd0);
        chk("add_dc", {32'd0, ALU_DC}, 64'h8000_0000);
        chk("add_hi", {32'd0, ALU_HI}, 64'd0);
        chk("add_zero", {63'd0, ALU_Zero}, 64'd0);
`ifdef ALU_OVF_EN
        chk("add_ovf", {63'd0, ALU_Overflow}, 64'd1);
`endif
        tick();
        chk("add_pulse", {63'd0, done}, 64'd0);
        chk("add_hold", {32'd0, ALU_DC}, 64'h8000_0000);

        // back-to-back sub then xor
        issue(3'b001, 32'd5, 32'd5);
        chk("sub_done", {63'd0, done}, 64'd1);
        chk("sub_dc", {32'd0, ALU_DC}, 64'd0);
        chk("sub_zero", {63'd0, ALU_Zero}, 64'd1);
`ifdef ALU_OVF_EN
        chk("sub_ovf", {63'd0, ALU_Overflow}, 64'd0);
`endif
        issue(3'b101, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        chk("xor_done", {63'd0, done}, 64'd1);
        chk("xor_dc", {32'd0, ALU_DC}, 64'hFFFF_FFFF);
        chk("xor_zero", {63'd0, ALU_Zero}, 64'd0);
        tick();

        // mul with an ignored start mid-CALC
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 1; i <= 32; i++) begin
            chk("mul_busy", {63'd0, busy}, 64'd1);
            chk("mul_nodone", {63'd0, done}, 64'd0);
            if (i == 5) begin
                start = 1'b1; ALUOp = 3'b000; ALU_DA = 32'd1; ALU_DB = 32'd2;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("mul_done", {63'd0, done}, 64'd1);
        chk("mul_busy_end", {63'd0, busy}, 64'd0);
        chk("mul_prod", {ALU_HI, ALU_DC}, 64'hFFFF_FFFE_0000_0001);
        chk("mul_zero", {63'd0, ALU_Zero}, 64'd0);
        tick();
        chk("mul_pulse", {63'd0, done}, 64'd0);

        // div
        issue(3'b110, 32'd100, 32'd7);
        run_calc("div");
        chk("div_done", {63'd0, done}, 64'd1);
        chk("div_q", {32'd0, ALU_DC}, 64'd14);
        chk("div_r", {32'd0, ALU_HI}, 64'd2);
        tick();

        issue(3'b110, 32'h0000_1234, 32'd0);
        run_calc("div0");
        chk("div0_done", {63'd0, done}, 64'd1);
        chk("div0_q", {32'd0, ALU_DC}, 64'hFFFF_FFFF);
        chk("div0_r", {32'd0, ALU_HI}, 64'h1234);
        chk("div0_zero", {63'd0, ALU_Zero}, 64'd0);
        tick();

        // reserved op
        issue(3'b111, 32'h5555_5555, 32'hAAAA_AAAA);
        chk("rsv_done", {63'd0, done}, 64'd1);
        chk("rsv_dc", {32'd0, ALU_DC}, 64'd0);
        chk("rsv_hi", {32'd0, ALU_HI}, 64'd0);
        chk("rsv_zero", {63'd0, ALU_Zero}, 64'd1);
        tick();

        // give the outputs a non-zero value before the reset test
        issue(3'b100, 32'h0000_00F0, 32'h0000_000F);
        chk("or_dc", {32'd0, ALU_DC}, 64'hFF);

        // reset during mul, with start asserted alongside reset
        issue(3'b011, 32'd3, 32'd5);
        for (int i = 1; i < 10; i++) tick();
        reset = 1'b1; start = 1'b1; ALUOp = 3'b000; ALU_DA = 32'd9; ALU_DB = 32'd9;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_dc", {32'd0, ALU_DC}, 64'd0);
        chk("abort_hi", {32'd0, ALU_HI}, 64'd0);
        chk("abort_zero", {63'd0, ALU_Zero}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_nodone", {63'd0, done}, 64'd0);
            chk("abort_idle", {63'd0, busy}, 64'd0);
        end

        issue(3'b000, 32'd3, 32'd4);
        chk("add2_done", {63'd0, done}, 64'd1);
        chk("add2_dc", {32'd0, ALU_DC}, 64'd7);
        chk("add2_zero", {63'd0, ALU_Zero}, 64'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
